// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for the 32-word
// Data_Memory. Port 0 is the pipeline MEM stage, port 1 the debug/loader port.
// Each access runs IDLE -> ISSUE -> RESP -> IDLE (three cycles, no overlap).
// Optional feature macro: DMEM_ARB_RANGE_CHK_EN (out-of-range addresses are
// suppressed and flagged through err_o instead of wrapping).
module dmem_arbiter #(
    parameter int DEPTH_W = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [DATA_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              last_grant_r;
    logic              id_r;
    logic              we_lat_r;
    logic              range_err_r;
    logic              mem_write_r;
    logic              mem_read_r;
    logic [DATA_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_data_r;
    logic [1:0]        ack_r;
    logic              err_r;
    logic [DATA_W-1:0] rdata_hold_r;

    logic              grant_s;
    logic              start_s;
    logic              we_sel_s;
    logic              range_err_s;
    logic              unused_addr_s;
    logic [DATA_W-1:0] addr_sel_s;
    logic [DATA_W-1:0] wdata_sel_s;

    // Winner selection: single requester wins, a tie goes to the port not granted last.
    always_comb begin
        grant_s     = 1'b0;
        addr_sel_s  = addr0_i;
        wdata_sel_s = wdata0_i;
        we_sel_s    = we_i[0];
        case (req_i)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_r;
            default: grant_s = 1'b0;
        endcase
        if (grant_s) begin
            addr_sel_s  = addr1_i;
            wdata_sel_s = wdata1_i;
            we_sel_s    = we_i[1];
        end else begin
            addr_sel_s  = addr0_i;
            wdata_sel_s = wdata0_i;
            we_sel_s    = we_i[0];
        end
    end

`ifdef DMEM_ARB_RANGE_CHK_EN
    assign range_err_s = |addr_sel_s[DATA_W-1:DEPTH_W+2];
`else
    assign range_err_s = 1'b0;
`endif

    // Byte-offset bits never reach the memory; upper bits only matter for the range check.
    assign unused_addr_s = ^{addr_sel_s[1:0], addr_sel_s[DATA_W-1:DEPTH_W+2]};

    assign start_s = (state_r == ST_IDLE) && (req_i != 2'b00);

    // Next-state logic of the three-phase sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_RESP;
            ST_RESP:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register and round-robin history (updated when a grant enters ISSUE).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_s;
            if (start_s) begin
                last_grant_r <= grant_s;
            end
        end
    end

    // Latch the winning request and drive the memory strobes for exactly the ISSUE cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_r        <= 1'b0;
            we_lat_r    <= 1'b0;
            range_err_r <= 1'b0;
            mem_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_addr_r  <= {DATA_W{1'b0}};
            mem_data_r  <= {DATA_W{1'b0}};
        end else begin
            mem_write_r <= start_s & we_sel_s & ~range_err_s;
            mem_read_r  <= start_s & ~we_sel_s & ~range_err_s;
            if (start_s) begin
                id_r        <= grant_s;
                we_lat_r    <= we_sel_s;
                range_err_r <= range_err_s;
                mem_addr_r  <= {{(DATA_W-DEPTH_W){1'b0}}, addr_sel_s[DEPTH_W+1:2]};
                mem_data_r  <= wdata_sel_s;
            end
        end
    end

    // Completion pulse and error flag, raised for the RESP cycle only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_r <= 2'b00;
            err_r <= 1'b0;
        end else if (state_r == ST_ISSUE) begin
            ack_r <= id_r ? 2'b10 : 2'b01;
            err_r <= range_err_r;
        end else begin
            ack_r <= 2'b00;
            err_r <= 1'b0;
        end
    end

    // Read data: memory output during a read RESP, otherwise the last delivered value.
    always_comb begin
        rdata_o = rdata_hold_r;
        if ((state_r == ST_RESP) && !we_lat_r) begin
            if (range_err_r) begin
                rdata_o = {DATA_W{1'b0}};
            end else begin
                rdata_o = mem_data_i;
            end
        end else begin
            rdata_o = rdata_hold_r;
        end
    end

    // Keep the delivered read data stable between responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_hold_r <= {DATA_W{1'b0}};
        end else if (state_r == ST_RESP) begin
            rdata_hold_r <= rdata_o;
        end
    end

    assign ack_o       = ack_r;
    assign err_o       = err_r;
    assign busy_o      = (state_r != ST_IDLE);
    assign mem_write_o = mem_write_r;
    assign mem_read_o  = mem_read_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_data_o  = mem_data_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 32-word Data_Memory
// (write and registered read both take effect at the ISSUE edge).
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_i = 2'b00;
    logic [1:0]  we_i = 2'b00;
    logic [31:0] addr0_i = 32'h0;
    logic [31:0] wdata0_i = 32'h0;
    logic [31:0] addr1_i = 32'h0;
    logic [31:0] wdata1_i = 32'h0;
    logic [1:0]  ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;
    logic        mem_write_o;
    logic        mem_read_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    logic        mem_init = 1'b1;
    logic [31:0] mem_model [0:31];

    int errors = 0;
    int checks = 0;

`ifdef DMEM_ARB_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    dmem_arbiter #(.DEPTH_W(5), .DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr0_i     (addr0_i),
        .wdata0_i    (wdata0_i),
        .addr1_i     (addr1_i),
        .wdata1_i    (wdata1_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .mem_write_o (mem_write_o),
        .mem_read_o  (mem_read_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Data_Memory model: preset pattern, synchronous write and registered read.
    always @(posedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem_model[i] <= 32'h1000_0000 + i;
            mem_data_i <= 32'h0;
        end else begin
            if (mem_write_o) mem_model[mem_addr_o[4:0]] <= mem_data_o;
            if (mem_read_o)  mem_data_i <= mem_model[mem_addr_o[4:0]];
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Advance until an ack appears (at most 8 cycles); returns cycles taken or 99 on timeout.
    task automatic wait_ack(output int cycles);
        cycles = 99;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (ack_o != 2'b00) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = 2'b00;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        mem_init = 1'b0;
        checks++; if (ack_o !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", ack_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
        checks++;
        if ({mem_write_o, mem_read_o} !== 2'b00 || mem_addr_o !== 32'h0 || mem_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem got=%b%b/%h/%h exp=00/0/0", mem_write_o, mem_read_o, mem_addr_o, mem_data_o);
        end
        step();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_write_read();
        int cyc;
        req_i = 2'b01; we_i = 2'b01; addr0_i = 32'h10; wdata0_i = 32'hDEAD_BEEF;
        step();
        checks++;
        if (mem_write_o !== 1'b1 || mem_read_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL wr_issue_strobes got=w%b r%b b%b exp=w1 r0 b1", mem_write_o, mem_read_o, busy_o);
        end
        checks++; if (mem_addr_o !== 32'd4) begin errors++; $display("FAIL wr_issue_addr got=%0d exp=4", mem_addr_o); end
        checks++; if (mem_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_issue_data got=%h exp=deadbeef", mem_data_o); end
        addr0_i = 32'h0;
        step();
        checks++; if (ack_o !== 2'b01) begin errors++; $display("FAIL wr_ack got=%b exp=01", ack_o); end
        req_i = 2'b00; addr0_i = 32'h10;
        step();
        checks++;
        if (ack_o !== 2'b00 || busy_o !== 1'b0 || mem_write_o !== 1'b0) begin
            errors++; $display("FAIL wr_done got=a%b b%b w%b exp=a00 b0 w0", ack_o, busy_o, mem_write_o);
        end
        checks++; if (mem_model[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_commit got=%h exp=deadbeef", mem_model[4]); end
        req_i = 2'b01; we_i = 2'b00;
        wait_ack(cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", cyc); end
        checks++; if (ack_o !== 2'b01) begin errors++; $display("FAIL rd_ack got=%b exp=01", ack_o); end
        checks++; if (rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", rdata_o); end
        req_i = 2'b00;
        step();
    endtask

    task automatic test_round_robin();
        int cyc;
        logic [1:0]  exp_ack [0:3];
        logic [31:0] exp_data [0:3];
        exp_ack[0] = 2'b01; exp_data[0] = 32'hDEAD_BEEF;
        exp_ack[1] = 2'b10; exp_data[1] = 32'h1000_0005;
        exp_ack[2] = 2'b01; exp_data[2] = 32'hDEAD_BEEF;
        exp_ack[3] = 2'b10; exp_data[3] = 32'h1000_0005;
        do_reset();
        req_i = 2'b11; we_i = 2'b00; addr0_i = 32'h10; addr1_i = 32'h14;
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc);
            checks++;
            if (cyc !== ((k == 0) ? 2 : 3)) begin
                errors++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", k, cyc, (k == 0) ? 2 : 3);
            end
            checks++; if (ack_o !== exp_ack[k]) begin errors++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, ack_o, exp_ack[k]); end
            checks++; if (rdata_o !== exp_data[k]) begin errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, rdata_o, exp_data[k]); end
        end
        req_i = 2'b00;
        step();
    endtask

    task automatic test_misaligned();
        int cyc;
        req_i = 2'b10; we_i = 2'b10; addr1_i = 32'h13; wdata1_i = 32'h5;
        step();
        checks++;
        if (mem_addr_o !== 32'd4 || mem_write_o !== 1'b1) begin
            errors++; $display("FAIL mis_issue got=addr%0d w%b exp=addr4 w1", mem_addr_o, mem_write_o);
        end
        step();
        checks++; if (ack_o !== 2'b10) begin errors++; $display("FAIL mis_ack got=%b exp=10", ack_o); end
        checks++; if (rdata_o !== 32'h1000_0005) begin errors++; $display("FAIL mis_hold got=%h exp=10000005", rdata_o); end
        req_i = 2'b00;
        step();
        req_i = 2'b10; we_i = 2'b00; addr1_i = 32'h10;
        wait_ack(cyc);
        checks++; if (cyc !== 2 || ack_o !== 2'b10) begin errors++; $display("FAIL mis_rd_ack got=%0d/%b exp=2/10", cyc, ack_o); end
        checks++; if (rdata_o !== 32'h5) begin errors++; $display("FAIL mis_rd_data got=%h exp=5", rdata_o); end
        req_i = 2'b00;
        step();
    endtask

    task automatic test_range();
        int cyc;
        req_i = 2'b10; we_i = 2'b10; addr1_i = 32'h0; wdata1_i = 32'hA5A5_0000;
        wait_ack(cyc);
        checks++; if (cyc !== 2 || ack_o !== 2'b10) begin errors++; $display("FAIL rng_pre_ack got=%0d/%b exp=2/10", cyc, ack_o); end
        req_i = 2'b00;
        step();
        req_i = 2'b01; we_i = 2'b00; addr0_i = 32'h80;
        step();
        checks++;
        if (mem_read_o !== !RANGE_CHK || mem_write_o !== 1'b0 || mem_addr_o !== 32'd0) begin
            errors++; $display("FAIL rng_issue got=r%b w%b addr%0d exp=r%b w0 addr0", mem_read_o, mem_write_o, mem_addr_o, !RANGE_CHK);
        end
        step();
        checks++; if (ack_o !== 2'b01) begin errors++; $display("FAIL rng_ack got=%b exp=01", ack_o); end
        checks++; if (err_o !== RANGE_CHK) begin errors++; $display("FAIL rng_err got=%b exp=%b", err_o, RANGE_CHK); end
        checks++;
        if (rdata_o !== (RANGE_CHK ? 32'h0 : 32'hA5A5_0000)) begin
            errors++; $display("FAIL rng_data got=%h exp=%h", rdata_o, RANGE_CHK ? 32'h0 : 32'hA5A5_0000);
        end
        req_i = 2'b00;
        step();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rng_err_clear got=%b exp=0", err_o); end
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        req_i = 2'b01; we_i = 2'b01; addr0_i = 32'h20; wdata0_i = 32'h600D_F00D;
        step();
        checks++; if (mem_write_o !== 1'b1) begin errors++; $display("FAIL mid_issue got=%b exp=1", mem_write_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; req_i = 2'b00;
        checks++;
        if (ack_o !== 2'b00 || busy_o !== 1'b0 || mem_write_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset got=a%b b%b w%b exp=a00 b0 w0", ack_o, busy_o, mem_write_o);
        end
        checks++; if (mem_model[8] !== 32'h600D_F00D) begin errors++; $display("FAIL mid_commit got=%h exp=600df00d", mem_model[8]); end
        step();
        checks++; if (ack_o !== 2'b00) begin errors++; $display("FAIL mid_no_ack got=%b exp=00", ack_o); end
        req_i = 2'b01; we_i = 2'b00;
        wait_ack(cyc);
        checks++; if (cyc !== 2 || rdata_o !== 32'h600D_F00D) begin errors++; $display("FAIL mid_readback got=%0d/%h exp=2/600df00d", cyc, rdata_o); end
        req_i = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_misaligned();
        test_range();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
